// File: rtl/load_ext_stage.sv
// Load-data alignment and sign/zero extension stage with a single registered
// output beat under valid/ready handshake; misaligned accesses are flagged.
module load_ext_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_data,
  input  logic [$clog2(XLEN/8)-1:0]    in_offset,
  input  logic [1:0]                   in_size,
  input  logic                         in_sext,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_data,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_misalign
);

  localparam int unsigned OFF_W = $clog2(XLEN/8);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext_data;
  logic            misalign;
  logic            msb;
  int unsigned     fw;

  // Select the addressed field, then fill the upper bits with sign or zero.
  always_comb begin
    shifted  = in_data >> {in_offset, 3'b000};
    misalign = 1'b0;
    msb      = 1'b0;
    fw       = 8;
    ext_data = '0;
    case (in_size)
      2'b00: begin
        fw  = 8;
        msb = shifted[7];
      end
      2'b01: begin
        fw       = 16;
        msb      = shifted[15];
        misalign = in_offset[0];
      end
      2'b10: begin
        fw       = 32;
        msb      = shifted[31];
        misalign = |in_offset[1:0];
      end
      default: begin
        fw       = 64;
        msb      = shifted[XLEN-1];
        misalign = (XLEN == 32) || (|in_offset[OFF_W-1:0]);
      end
    endcase
    for (int unsigned i = 0; i < XLEN; i++) begin
      ext_data[i] = (i < fw) ? shifted[i] : (in_sext & msb);
    end
    if (misalign) begin
      ext_data = '0;
    end
  end

  assign in_ready = !out_valid || out_ready;

  // Output register: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_tag      <= '0;
      out_misalign <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid    <= 1'b1;
      out_data     <= ext_data;
      out_tag      <= in_tag;
      out_misalign <= misalign;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
